// File: rtl/triangle_sweep_if.sv
// Control/sample bundle between a sweep controller (master) and the
// triangle_sweep generator (slave).
interface triangle_sweep_if #(
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int STEP_W          = 32
);
    logic                              on_in;
    logic                              mode_in;
    logic signed [SIGNAL_OUT_SIZE-1:0] minval_in;
    logic signed [SIGNAL_OUT_SIZE-1:0] maxval_in;
    logic        [STEP_W-1:0]          stepsize_in;
    logic signed [SIGNAL_OUT_SIZE-1:0] signal_out;
    logic                              dir_out;
    logic                              cycle_out;

    modport master (
        output on_in, mode_in, minval_in, maxval_in, stepsize_in,
        input  signal_out, dir_out, cycle_out
    );

    modport slave (
        input  on_in, mode_in, minval_in, maxval_in, stepsize_in,
        output signal_out, dir_out, cycle_out
    );
endinterface

// File: rtl/triangle_sweep.sv
// Sawtooth/triangle sweep generator for the DAC sample path: fractional
// accumulator, per-sweep latched bounds, exact clamping and a sweep-start strobe.
module triangle_sweep #(
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int FRAC_BITS       = 16
) (
    input logic             clk_in,
    input logic             rst_in,
    triangle_sweep_if.slave bus
);
    localparam int ACC_W = SIGNAL_OUT_SIZE + FRAC_BITS;

    typedef enum logic [2:0] {IDLE, HOLD, UP, TOP, DOWN} state_t;

    state_t                            state;
    logic signed [ACC_W-1:0]           acc;
    logic signed [SIGNAL_OUT_SIZE-1:0] min_l, max_l;
    logic        [ACC_W-1:0]           step_l;
    logic                              mode_l;
    logic                              dir_r, cycle_r;

    logic signed [ACC_W-1:0] min_acc, max_acc, live_min_acc;
    logic signed [ACC_W+1:0] acc_x, min_x, max_x, nxt_up, nxt_dn;
    logic                    up_hit, dn_hit, degen, load_set;

    // Two guard bits keep acc +/- a full 32-bit step from wrapping.
    always_comb begin
        min_acc      = {min_l, {FRAC_BITS{1'b0}}};
        max_acc      = {max_l, {FRAC_BITS{1'b0}}};
        live_min_acc = {bus.minval_in, {FRAC_BITS{1'b0}}};
        acc_x        = {{2{acc[ACC_W-1]}}, acc};
        min_x        = {{2{min_acc[ACC_W-1]}}, min_acc};
        max_x        = {{2{max_acc[ACC_W-1]}}, max_acc};
        nxt_up       = acc_x + $signed({2'b00, step_l});
        nxt_dn       = acc_x - $signed({2'b00, step_l});
        up_hit       = nxt_up >= max_x;
        dn_hit       = nxt_dn <= min_x;
        degen        = bus.minval_in >= bus.maxval_in;
        load_set     = !bus.on_in || state == IDLE || state == TOP ||
                       (state == DOWN && dn_hit);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            min_l  <= '0;
            max_l  <= '0;
            step_l <= '0;
            mode_l <= 1'b0;
        end else if (load_set) begin
            min_l  <= bus.minval_in;
            max_l  <= bus.maxval_in;
            step_l <= bus.stepsize_in;
            mode_l <= bus.mode_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            acc     <= '0;
            dir_r   <= 1'b0;
            cycle_r <= 1'b0;
        end else begin
            cycle_r <= 1'b0;
            dir_r   <= 1'b0;
            if (!bus.on_in) begin
                state <= IDLE;
                acc   <= live_min_acc;
            end else begin
                case (state)
                    IDLE: begin
                        acc     <= live_min_acc;
                        cycle_r <= 1'b1;
                        state   <= degen ? HOLD : UP;
                        dir_r   <= !degen;
                    end
                    HOLD: acc <= min_acc;
                    UP: begin
                        if (up_hit) begin
                            acc   <= max_acc;
                            state <= mode_l ? DOWN : TOP;
                            dir_r <= !mode_l;
                        end else begin
                            acc   <= nxt_up[ACC_W-1:0];
                            dir_r <= 1'b1;
                        end
                    end
                    TOP: begin
                        acc     <= min_acc;
                        cycle_r <= 1'b1;
                        state   <= degen ? HOLD : UP;
                        dir_r   <= !degen;
                    end
                    DOWN: begin
                        if (dn_hit) begin
                            acc     <= min_acc;
                            cycle_r <= 1'b1;
                            state   <= degen ? HOLD : UP;
                            dir_r   <= !degen;
                        end else begin
                            acc <= nxt_dn[ACC_W-1:0];
                        end
                    end
                    default: begin
                        state <= IDLE;
                        acc   <= live_min_acc;
                    end
                endcase
            end
        end
    end

    assign bus.signal_out = acc[ACC_W-1 -: SIGNAL_OUT_SIZE];
    assign bus.dir_out    = dir_r;
    assign bus.cycle_out  = cycle_r;
endmodule

// File: tb/tb_triangle_sweep.sv
// Bench for triangle_sweep: directed waveform checks plus a randomized run
// compared every cycle against a sample-level sweep model.
module tb_triangle_sweep;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    triangle_sweep_if bus ();
    triangle_sweep dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    endtask

    // Model: sweep tracked as an exact position in 1/65536 sample units.
    localparam int P_IDLE = 0, P_HOLD = 1, P_UP = 2, P_TOP = 3, P_DOWN = 4;
    int     ph;
    longint pos, lstep;
    int     lmin, lmax;
    bit     lmode, dir_m, cyc_m;

    function automatic longint sc(input int v);
        return longint'(v) * 65536;
    endfunction

    task automatic new_sweep(input longint at);
        lmin  = bus.minval_in;
        lmax  = bus.maxval_in;
        lstep = longint'(bus.stepsize_in);
        lmode = bus.mode_in;
        pos   = at;
        cyc_m = 1'b1;
        ph    = (lmin >= lmax) ? P_HOLD : P_UP;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = P_IDLE; pos = 0; lmin = 0; lmax = 0; lstep = 0; lmode = 0;
            dir_m = 0; cyc_m = 0;
        end else begin
            cyc_m = 1'b0;
            if (!bus.on_in) begin
                ph  = P_IDLE;
                pos = sc(bus.minval_in);
            end else begin
                case (ph)
                    P_IDLE: new_sweep(sc(bus.minval_in));
                    P_HOLD: pos = sc(lmin);
                    P_UP:
                        if (pos + lstep >= sc(lmax)) begin
                            pos = sc(lmax);
                            ph  = lmode ? P_DOWN : P_TOP;
                        end else pos += lstep;
                    P_TOP: new_sweep(sc(lmin));
                    P_DOWN:
                        if (pos - lstep <= sc(lmin)) new_sweep(sc(lmin));
                        else pos -= lstep;
                    default: ph = P_IDLE;
                endcase
            end
            dir_m = (ph == P_UP || ph == P_TOP);
        end
    end

    always @(negedge clk) begin
        chk("model_sig", longint'(bus.signal_out), pos >>> 16);
        chk("model_dir", longint'(bus.dir_out), longint'(dir_m));
        chk("model_cyc", longint'(bus.cycle_out), longint'(cyc_m));
    end

    int eq[$];
    bit ec[$];
    bit ed[$];

    task automatic start(input int mn, input int mx, input logic [31:0] st, input bit md);
        bus.on_in       = 1'b0;
        bus.minval_in   = 16'(mn);
        bus.maxval_in   = 16'(mx);
        bus.stepsize_in = st;
        bus.mode_in     = md;
        @(negedge clk);
        bus.on_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_q(input string nm);
        for (int i = 0; i < eq.size(); i++) begin
            chk({nm, "_sig"}, longint'(bus.signal_out), longint'(eq[i]));
            chk({nm, "_cyc"}, longint'(bus.cycle_out), longint'(ec[i]));
            if (ed.size() > 0) chk({nm, "_dir"}, longint'(bus.dir_out), longint'(ed[i]));
            @(negedge clk);
        end
        ed = {};
    endtask

    initial begin
        int v;
        rst = 1'b1;
        bus.on_in = 0; bus.mode_in = 0; bus.minval_in = 0; bus.maxval_in = 0;
        bus.stepsize_in = 0;
        #1;
        chk("reset_sig", longint'(bus.signal_out), 0);
        chk("reset_dir", longint'(bus.dir_out), 0);
        chk("reset_cyc", longint'(bus.cycle_out), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        start(-4, 4, 32'h10000, 1'b1);
        eq = '{-4,-3,-2,-1,0,1,2,3,4,3,2,1,0,-1,-2,-3,-4};
        ec = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};
        ed = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,1};
        check_q("tri");

        start(-4, 4, 32'h10000, 1'b0);
        eq = '{-4,-3,-2,-1,0,1,2,3,4,-4,-3};
        ec = '{1,0,0,0,0,0,0,0,0,1,0};
        check_q("saw");

        start(0, 10, 32'h30000, 1'b1);
        eq = '{0,3,6,9,10,7,4,1,0,3};
        ec = '{1,0,0,0,0,0,0,0,1,0};
        ed = '{1,1,1,1,0,0,0,0,1,1};
        check_q("ovr");

        start(0, 3, 32'h8000, 1'b1);
        eq = '{0,0,1,1,2,2,3};
        ec = '{1,0,0,0,0,0,0};
        check_q("frac");

        start(-32768, 32767, 32'hFFFF_FFFF, 1'b1);
        eq = '{-32768,32767,-32768,32767,-32768};
        ec = '{1,0,1,0,1};
        check_q("full");

        start(5, 5, 32'h10000, 1'b1);
        eq = '{5,5,5,5};
        ec = '{1,0,0,0};
        ed = '{0,0,0,0};
        check_q("degen");

        start(0, 4, 32'h10000, 1'b1);
        eq = '{0,1,2};
        ec = '{1,0,0};
        check_q("midmax_a");
        bus.maxval_in = 16'sd6;
        eq = '{3,4,3,2,1,0,1,2,3,4,5,6,5};
        ec = '{0,0,0,0,0,1,0,0,0,0,0,0,0};
        check_q("midmax_b");

        start(-10, 10, 32'h10000, 1'b1);
        eq = '{-10,-9,-8};
        ec = '{1,0,0};
        check_q("dis_a");
        bus.on_in = 1'b0;
        bus.minval_in = 16'sd7;
        @(negedge clk);
        chk("dis_sig", longint'(bus.signal_out), 7);
        chk("dis_cyc", longint'(bus.cycle_out), 0);
        bus.minval_in = -16'sd2;
        @(negedge clk);
        chk("idle_follow", longint'(bus.signal_out), -2);

        start(0, 5, 32'h10000, 1'b1);
        eq = '{0,1,2,3,4,5,4};
        ec = '{1,0,0,0,0,0,0};
        check_q("rst_a");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sig", longint'(bus.signal_out), 0);
        chk("async_rst_dir", longint'(bus.dir_out), 0);
        chk("async_rst_cyc", longint'(bus.cycle_out), 0);
        @(negedge clk);
        rst = 1'b0;

        bus.on_in = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(99) < 3) begin
                v = $urandom_range(40);
                bus.minval_in = 16'(v - 20);
                v = $urandom_range(40);
                bus.maxval_in = 16'(v - 20);
                bus.mode_in = 1'($urandom_range(1));
                bus.stepsize_in = 32'($urandom_range(32'h40000, 32'h800));
                if ($urandom_range(19) == 0) bus.stepsize_in = 32'h0;
                if ($urandom_range(9) == 0) begin
                    bus.minval_in = -16'sd32768;
                    bus.maxval_in = 16'sd32767;
                    bus.stepsize_in = $urandom;
                end
            end
            if ($urandom_range(99) < 2) bus.on_in = ~bus.on_in;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
